// File: rtl/fir_out_fifo.sv
// Elastic show-ahead output FIFO between the FIR (no backpressure) and a READY-handshaked sink.
// Optional macro FOF_DROP_CNT_EN adds a saturating 16-bit DROPS counter port.
module fir_out_fifo #(
  parameter int NBIT  = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic signed [NBIT-1:0] DIN,
  input  logic                   VIN,
  output logic signed [NBIT-1:0] DOUT,
  output logic                   VOUT,
  input  logic                   READY,
  output logic [AW:0]            COUNT,
  output logic                   FULL,
  output logic                   OVF
`ifdef FOF_DROP_CNT_EN
  ,
  output logic [15:0]            DROPS
`endif
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic signed [NBIT-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          ovf;
  logic          wr;
  logic          rd;
  logic          drop;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Occupancy, not pointer equality, decides full/empty; a read frees a slot for a same-cycle write.
  always_comb begin
    VOUT  = (count != '0);
    FULL  = (count == FULL_CNT);
    rd    = VOUT & READY;
    wr    = VIN & (~FULL | rd);
    drop  = VIN & FULL & ~rd;
    COUNT = count;
    OVF   = ovf;
    DOUT  = VOUT ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      if (wr && !rd)      count <= count + 1'b1;
      else if (rd && !wr) count <= count - 1'b1;
      if (drop) ovf <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr && !RST) mem[wr_ptr] <= DIN;
  end

`ifdef FOF_DROP_CNT_EN
  logic [15:0] drops;

  always_ff @(posedge CLK) begin
    if (RST)       drops <= '0;
    else if (drop) drops <= sat_inc(drops);
  end

  assign DROPS = drops;
`endif

endmodule

// File: tb/tb_fir_out_fifo.sv
// Scoreboard bench for fir_out_fifo: a queue holds the samples the FIFO should contain;
// a negedge monitor pops and compares on every handshake, scenario tasks check flags inline.
module tb_fir_out_fifo;
  localparam int NBIT  = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic                   CLK = 1'b0;
  logic                   RST = 1'b1;
  logic signed [NBIT-1:0] DIN = '0;
  logic                   VIN = 1'b0;
  logic                   READY = 1'b0;
  logic signed [NBIT-1:0] DOUT;
  logic                   VOUT;
  logic [AW:0]            COUNT;
  logic                   FULL;
  logic                   OVF;
`ifdef FOF_DROP_CNT_EN
  logic [15:0]            DROPS;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic signed [NBIT-1:0] sb[$];
  logic exp_ovf   = 1'b0;
  int   exp_drops = 0;

  always #5 CLK = ~CLK;

  fir_out_fifo #(.NBIT(NBIT), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .VIN(VIN), .DOUT(DOUT), .VOUT(VOUT),
    .READY(READY), .COUNT(COUNT), .FULL(FULL), .OVF(OVF)
`ifdef FOF_DROP_CNT_EN
    , .DROPS(DROPS)
`endif
  );

  // Monitor: occupancy/valid vs. the scoreboard, and ordered data on every accepted handshake.
  always @(negedge CLK) begin
    logic signed [NBIT-1:0] exp;
    if (RST === 1'b0) begin
      n_checks++;
      if (VOUT !== (sb.size() != 0)) begin
        n_fail++;
        $display("FAIL vout_flag: got %b want %b", VOUT, (sb.size() != 0));
      end
      n_checks++;
      if (COUNT !== (AW+1)'(sb.size())) begin
        n_fail++;
        $display("FAIL count_track: got %0d want %0d", COUNT, sb.size());
      end
      if (VOUT === 1'b1 && READY === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL dout_order: got %0d want nothing", DOUT);
        end else begin
          exp = sb.pop_front();
          if (DOUT !== exp) begin
            n_fail++;
            $display("FAIL dout_order: got %0d want %0d", DOUT, exp);
          end
        end
      end else if (VOUT === 1'b0) begin
        n_checks++;
        if (DOUT !== '0) begin
          n_fail++;
          $display("FAIL dout_idle: got %0d want 0", DOUT);
        end
      end
    end
  end

  // Drive one cycle; after the monitor's pop, the model decides whether the write lands or drops.
  task automatic drive(input logic vin, input logic signed [NBIT-1:0] din, input logic rdy);
    VIN = vin; DIN = din; READY = rdy;
    @(negedge CLK); #1;
    if (vin && !RST) begin
      if (sb.size() < DEPTH) sb.push_back(din);
      else begin
        exp_ovf = 1'b1;
        if (exp_drops < 65535) exp_drops++;
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    drive(1'b1, 8'sd55, 1'b1);
    drive(1'b1, 8'sd56, 1'b1);
    RST = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
    exp_drops = 0;
    n_checks++;
    if (COUNT !== '0 || VOUT !== 1'b0 || DOUT !== '0 || OVF !== 1'b0 || FULL !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got count=%0d vout=%b dout=%0d ovf=%b full=%b want 0 0 0 0 0",
               COUNT, VOUT, DOUT, OVF, FULL);
    end
`ifdef FOF_DROP_CNT_EN
    n_checks++;
    if (DROPS !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_drops: got %0d want 0", DROPS);
    end
`endif
  endtask

  task automatic test_single();
    drive(1'b1, 8'sd10, 1'b1);
    n_checks++;
    if (VOUT !== 1'b1 || DOUT !== 8'sd10 || COUNT !== 4'd1) begin
      n_fail++;
      $display("FAIL single_latency: got vout=%b dout=%0d count=%0d want 1 10 1", VOUT, DOUT, COUNT);
    end
    drive(1'b0, 8'sd0, 1'b1);
    n_checks++;
    if (COUNT !== 4'd0 || VOUT !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain: got count=%0d vout=%b want 0 0", COUNT, VOUT);
    end
  endtask

  task automatic fill(input int base);
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b1, 8'(base + i), 1'b0);
      n_checks++;
      if (VOUT !== 1'b1 || DOUT !== 8'(base + 1)) begin
        n_fail++;
        $display("FAIL stall_stable: got vout=%b dout=%0d want 1 %0d", VOUT, DOUT, base + 1);
      end
    end
    n_checks++;
    if (FULL !== 1'b1 || COUNT !== 4'd8) begin
      n_fail++;
      $display("FAIL full_flag: got full=%b count=%0d want 1 8", FULL, COUNT);
    end
  endtask

  task automatic drain_check_empty();
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 8'sd0, 1'b1);
    n_checks++;
    if (VOUT !== 1'b0 || COUNT !== 4'd0 || FULL !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty: got vout=%b count=%0d full=%b want 0 0 0", VOUT, COUNT, FULL);
    end
  endtask

  task automatic test_fill_drain();
    fill(0);
    drain_check_empty();
  endtask

  task automatic test_overflow();
    fill(10);
    drive(1'b1, 8'sd99, 1'b0);
    n_checks++;
    if (OVF !== exp_ovf || OVF !== 1'b1 || COUNT !== 4'd8) begin
      n_fail++;
      $display("FAIL overflow: got ovf=%b count=%0d want 1 8", OVF, COUNT);
    end
`ifdef FOF_DROP_CNT_EN
    n_checks++;
    if (DROPS !== 16'(exp_drops)) begin
      n_fail++;
      $display("FAIL drop_count: got %0d want %0d", DROPS, exp_drops);
    end
`endif
  endtask

  task automatic test_full_read_write();
    drive(1'b1, 8'sd50, 1'b1);
    n_checks++;
    if (COUNT !== 4'd8 || FULL !== 1'b1) begin
      n_fail++;
      $display("FAIL full_rw: got count=%0d full=%b want 8 1", COUNT, FULL);
    end
    drain_check_empty();
    n_checks++;
    if (OVF !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %b want 1", OVF);
    end
  endtask

  task automatic test_stream_wrap();
    int sent;
    RST = 1'b1;
    drive(1'b0, 8'sd0, 1'b0);
    RST = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
    exp_drops = 0;
    sent = 0;
    for (int c = 0; sent < 20; c++) begin
      if (c % 3 != 2) begin
        drive(1'b1, 8'(30 + sent), (c % 2) == 0);
        sent++;
      end else begin
        drive(1'b0, 8'sd0, (c % 2) == 0);
      end
    end
    n_checks++;
    if (OVF !== 1'b0 || OVF !== exp_ovf) begin
      n_fail++;
      $display("FAIL stream_ovf: got %b want 0", OVF);
    end
    n_checks++;
    if (COUNT === 4'd0) begin
      n_fail++;
      $display("FAIL stream_backlog: got count=0 want nonzero before reset");
    end
    RST = 1'b1;
    drive(1'b1, 8'sd120, 1'b1);
    RST = 1'b0;
    sb.delete();
    n_checks++;
    if (COUNT !== 4'd0 || VOUT !== 1'b0 || DOUT !== '0) begin
      n_fail++;
      $display("FAIL midburst_reset: got count=%0d vout=%b dout=%0d want 0 0 0", COUNT, VOUT, DOUT);
    end
    drive(1'b1, 8'sd77, 1'b1);
    drive(1'b0, 8'sd0, 1'b1);
    n_checks++;
    if (COUNT !== 4'd0) begin
      n_fail++;
      $display("FAIL post_reset: got count=%0d want 0", COUNT);
    end
  endtask

  initial begin
    @(posedge CLK); #1;
    test_reset();
    test_single();
    test_fill_drain();
    test_overflow();
    test_full_read_write();
    test_stream_wrap();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d queued want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
